// File: rtl/mem_stage_unit_pkg.sv
// Shared encodings for the MEM stage: access sizes, branch types and lane widths.
package mem_stage_unit_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;

  localparam int NB_BYTE = 8;
  localparam int NB_HALF = 16;

endpackage

// File: rtl/mem_stage_unit_if.sv
// EX/MEM inputs and MEM/WB outputs of the MEM stage, grouped as one bus.
interface mem_stage_unit_if #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_PC   = 32
);
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] i_rf_data;
  logic               i_wr_enable;
  logic               i_rd_enable;
  logic [1:0]         i_access_size;
  logic               i_unsigned;
  logic [1:0]         i_branch_type;
  logic               i_alu_zero;
  logic [NB_PC-1:0]   i_calculated_branch_addr;
  logic               i_rf_wr_enb;
  logic               i_rf_wr_data_src;
  logic [NB_REG-1:0]  i_rf_wr_addr;
  logic               i_stall;
  logic               i_flush;

  logic [NB_DATA-1:0] o_data_readed_ltchd;
  logic [NB_DATA-1:0] o_alu_result_ltchd;
  logic               o_rf_wr_enb_ltchd;
  logic               o_rf_wr_data_src_ltchd;
  logic [NB_REG-1:0]  o_rf_wr_addr_ltchd;
  logic               o_misaligned_ltchd;
  logic               o_pc_source;
  logic [NB_PC-1:0]   o_branch_addr;

  modport master (
    output i_alu_result, i_rf_data, i_wr_enable, i_rd_enable, i_access_size, i_unsigned,
           i_branch_type, i_alu_zero, i_calculated_branch_addr, i_rf_wr_enb,
           i_rf_wr_data_src, i_rf_wr_addr, i_stall, i_flush,
    input  o_data_readed_ltchd, o_alu_result_ltchd, o_rf_wr_enb_ltchd,
           o_rf_wr_data_src_ltchd, o_rf_wr_addr_ltchd, o_misaligned_ltchd,
           o_pc_source, o_branch_addr
  );

  modport slave (
    input  i_alu_result, i_rf_data, i_wr_enable, i_rd_enable, i_access_size, i_unsigned,
           i_branch_type, i_alu_zero, i_calculated_branch_addr, i_rf_wr_enb,
           i_rf_wr_data_src, i_rf_wr_addr, i_stall, i_flush,
    output o_data_readed_ltchd, o_alu_result_ltchd, o_rf_wr_enb_ltchd,
           o_rf_wr_data_src_ltchd, o_rf_wr_addr_ltchd, o_misaligned_ltchd,
           o_pc_source, o_branch_addr
  );
endinterface

// File: rtl/mem_stage_unit_data_memory_be.sv
// Word-organised RAM with per-byte write enables and a registered, read-before-write output.
module data_memory_be
  import mem_stage_unit_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 10
) (
  input  logic                                      i_clock,
  input  logic [NB_DATA/NB_BYTE-1:0]                i_wr_enb,
  input  logic                                      i_rd_enb,
  input  logic [NB_ADDR-$clog2(NB_DATA/NB_BYTE)-1:0] i_addr,
  input  logic [NB_DATA-1:0]                        i_data,
  output logic [NB_DATA-1:0]                        o_data
);
  localparam int NB_LANES  = NB_DATA / NB_BYTE;
  localparam int LANE_BITS = $clog2(NB_LANES);
  localparam int DEPTH     = 2 ** (NB_ADDR - LANE_BITS);

  logic [NB_DATA-1:0] mem_q [DEPTH];

  // Read samples the pre-write contents, so a same-cycle load sees the old word.
  always_ff @(posedge i_clock) begin
    if (i_rd_enb) o_data <= mem_q[i_addr];
    for (int b = 0; b < NB_LANES; b++) begin
      if (i_wr_enb[b]) mem_q[i_addr][b*NB_BYTE +: NB_BYTE] <= i_data[b*NB_BYTE +: NB_BYTE];
    end
  end
endmodule

// File: rtl/mem_stage_unit.sv
// MEM stage: sized loads/stores with misalignment trap, BEQ/BNE resolution, MEM/WB register.
module mem_stage_unit
  import mem_stage_unit_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 10,
  parameter int NB_REG  = 5,
  parameter int NB_PC   = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  mem_stage_unit_if.slave  bus
);
  localparam int NB_LANES  = NB_DATA / NB_BYTE;
  localparam int LANE_BITS = $clog2(NB_LANES);

  logic [NB_ADDR-1:0]   addr;
  logic [LANE_BITS-1:0] offset;
  logic                 is_byte, is_half, is_word, mis, acc;
  logic [NB_LANES-1:0]  be, wr_enb;
  logic [NB_DATA-1:0]   wr_data, mem_rd_data, load_ext;
  logic [NB_PC-1:0]     branch_addr;
  logic                 rf_wr_enb_d;

  logic [NB_DATA-1:0]   alu_q;
  logic                 rf_wr_enb_q, rf_src_q, mis_q, uns_q, valid_q;
  logic [NB_REG-1:0]    rf_addr_q;
  logic [1:0]           size_q;
  logic [LANE_BITS-1:0] off_q;

  assign addr    = bus.i_alu_result[NB_ADDR-1:0];
  assign offset  = addr[LANE_BITS-1:0];
  assign is_byte = (bus.i_access_size == SIZE_BYTE);
  assign is_half = (bus.i_access_size == SIZE_HALF);
  assign is_word = bus.i_access_size[1];
  assign mis     = (bus.i_rd_enable | bus.i_wr_enable)
                 & ((is_half & offset[0]) | (is_word & (offset != '0)));
  assign acc     = ~bus.i_stall & ~bus.i_flush & ~mis;

  always_comb begin
    wr_data = bus.i_rf_data;
    be      = '1;
    if (is_byte) begin
      wr_data    = {NB_LANES{bus.i_rf_data[NB_BYTE-1:0]}};
      be         = '0;
      be[offset] = 1'b1;
    end else if (is_half) begin
      wr_data = {(NB_DATA/NB_HALF){bus.i_rf_data[NB_HALF-1:0]}};
      be      = '0;
      be[{offset[LANE_BITS-1:1], 1'b0}] = 1'b1;
      be[{offset[LANE_BITS-1:1], 1'b1}] = 1'b1;
    end
  end

  // A store coinciding with a reset edge is dropped.
  assign wr_enb = be & {NB_LANES{acc & bus.i_wr_enable & ~i_reset}};

  data_memory_be #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) u_dmem (
    .i_clock  (i_clock),
    .i_wr_enb (wr_enb),
    .i_rd_enb (acc & bus.i_rd_enable),
    .i_addr   (addr[NB_ADDR-1:LANE_BITS]),
    .i_data   (wr_data),
    .o_data   (mem_rd_data)
  );

  assign rf_wr_enb_d = bus.i_rf_wr_enb & ~(mis & bus.i_rd_enable);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      alu_q       <= '0;
      rf_wr_enb_q <= 1'b0;
      rf_src_q    <= 1'b0;
      rf_addr_q   <= '0;
      mis_q       <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
      uns_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else if (bus.i_flush) begin
      rf_wr_enb_q <= 1'b0;
      mis_q       <= 1'b0;
    end else if (!bus.i_stall) begin
      alu_q       <= bus.i_alu_result;
      rf_wr_enb_q <= rf_wr_enb_d;
      rf_src_q    <= bus.i_rf_wr_data_src;
      rf_addr_q   <= bus.i_rf_wr_addr;
      mis_q       <= mis;
      size_q      <= bus.i_access_size;
      off_q       <= offset;
      uns_q       <= bus.i_unsigned;
      if (acc && bus.i_rd_enable) valid_q <= 1'b1;
    end
  end

  // The RAM output register has no reset; valid_q keeps it hidden until the first real load.
  always_comb begin
    load_ext = mem_rd_data;
    case (size_q)
      SIZE_BYTE: load_ext = uns_q
        ? {{(NB_DATA-NB_BYTE){1'b0}}, mem_rd_data[{off_q, 3'b000} +: NB_BYTE]}
        : {{(NB_DATA-NB_BYTE){mem_rd_data[{off_q, 3'b111}]}}, mem_rd_data[{off_q, 3'b000} +: NB_BYTE]};
      SIZE_HALF: load_ext = uns_q
        ? {{(NB_DATA-NB_HALF){1'b0}}, mem_rd_data[{off_q[LANE_BITS-1:1], 4'b0000} +: NB_HALF]}
        : {{(NB_DATA-NB_HALF){mem_rd_data[{off_q[LANE_BITS-1:1], 4'b1111}]}},
           mem_rd_data[{off_q[LANE_BITS-1:1], 4'b0000} +: NB_HALF]};
      default:   load_ext = mem_rd_data;
    endcase
  end

  assign branch_addr = bus.i_calculated_branch_addr;

  assign bus.o_data_readed_ltchd    = (valid_q & ~mis_q) ? load_ext : '0;
  assign bus.o_alu_result_ltchd     = alu_q;
  assign bus.o_rf_wr_enb_ltchd      = rf_wr_enb_q;
  assign bus.o_rf_wr_data_src_ltchd = rf_src_q;
  assign bus.o_rf_wr_addr_ltchd     = rf_addr_q;
  assign bus.o_misaligned_ltchd     = mis_q;
  assign bus.o_pc_source = ~bus.i_flush & (((bus.i_branch_type == BR_BEQ) & bus.i_alu_zero)
                                         | ((bus.i_branch_type == BR_BNE) & ~bus.i_alu_zero));
  assign bus.o_branch_addr = branch_addr;
endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit with a byte-array reference model and expectation queue.
`timescale 1ns/1ps
module tb_mem_stage_unit;
  import mem_stage_unit_pkg::*;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 10;
  localparam int NB_REG  = 5;
  localparam int NB_PC   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_unit_if #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_PC(NB_PC)) bus ();

  mem_stage_unit #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_REG(NB_REG), .NB_PC(NB_PC)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] model_mem [1024];

  typedef struct {
    string       tag;
    logic        chk_data;
    logic [31:0] data;
    logic        wen;
    logic        src;
    logic [4:0]  wa;
    logic        mis;
    logic [31:0] alu;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [9:0] a, input logic [1:0] sz, input logic uns);
    logic [9:0]  w;
    logic [7:0]  b;
    logic [15:0] h;
    w = {a[9:2], 2'b00};
    b = model_mem[a];
    h = {model_mem[a + 10'd1], model_mem[a]};
    if (sz == SIZE_BYTE) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (sz == SIZE_HALF) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return {model_mem[w + 10'd3], model_mem[w + 10'd2], model_mem[w + 10'd1], model_mem[w]};
  endfunction

  task automatic model_store(input logic [9:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [9:0] w;
    w = {a[9:2], 2'b00};
    if (sz == SIZE_BYTE) model_mem[a] = d[7:0];
    else if (sz == SIZE_HALF) begin
      model_mem[a] = d[7:0];
      model_mem[a + 10'd1] = d[15:8];
    end else begin
      model_mem[w] = d[7:0];
      model_mem[w + 10'd1] = d[15:8];
      model_mem[w + 10'd2] = d[23:16];
      model_mem[w + 10'd3] = d[31:24];
    end
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    last_e = e;
    if (e.chk_data) check({e.tag, "_data"}, bus.o_data_readed_ltchd, e.data);
    check({e.tag, "_wen"}, 32'(bus.o_rf_wr_enb_ltchd), 32'(e.wen));
    check({e.tag, "_mis"}, 32'(bus.o_misaligned_ltchd), 32'(e.mis));
    check({e.tag, "_alu"}, bus.o_alu_result_ltchd, e.alu);
    check({e.tag, "_wa"},  32'(bus.o_rf_wr_addr_ltchd), 32'(e.wa));
    check({e.tag, "_src"}, 32'(bus.o_rf_wr_data_src_ltchd), 32'(e.src));
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [1:0] sz, input logic uns,
                       input logic [31:0] alu, input logic [31:0] data, input logic wen,
                       input logic [4:0] wa, input logic stall, input logic flush);
    bus.i_wr_enable      = wr;
    bus.i_rd_enable      = rd;
    bus.i_access_size    = sz;
    bus.i_unsigned       = uns;
    bus.i_alu_result     = alu;
    bus.i_rf_data        = data;
    bus.i_rf_wr_enb      = wen;
    bus.i_rf_wr_data_src = rd;
    bus.i_rf_wr_addr     = wa;
    bus.i_stall          = stall;
    bus.i_flush          = flush;
    bus.i_branch_type    = BR_NONE;
    bus.i_alu_zero       = 1'b0;
  endtask

  task automatic op(input string tag, input logic wr, input logic rd, input logic [1:0] sz,
                    input logic uns, input logic [31:0] alu, input logic [31:0] data,
                    input logic wen, input logic [4:0] wa);
    exp_t e;
    logic m;
    logic [9:0] a;
    a = alu[9:0];
    @(negedge clk);
    drive(wr, rd, sz, uns, alu, data, wen, wa, 1'b0, 1'b0);
    m = (wr | rd) && ((sz == SIZE_HALF && a[0]) || (sz[1] && a[1:0] != 2'b00));
    e.tag      = tag;
    e.chk_data = rd;
    e.data     = m ? 32'h0 : model_load(a, sz, uns);
    e.wen      = wen & ~(m & rd);
    e.src      = rd;
    e.wa       = wa;
    e.mis      = m;
    e.alu      = alu;
    if (wr && !m) model_store(a, sz, data);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  task automatic check_frozen(input string tag);
    check({tag, "_alu"},  bus.o_alu_result_ltchd, last_e.alu);
    check({tag, "_wen"},  32'(bus.o_rf_wr_enb_ltchd), 32'(last_e.wen));
    check({tag, "_wa"},   32'(bus.o_rf_wr_addr_ltchd), 32'(last_e.wa));
    check({tag, "_data"}, bus.o_data_readed_ltchd, last_e.data);
  endtask

  logic exp_pc;

  initial begin
    drive(1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus.i_calculated_branch_addr = 32'h0;
    #12;
    check("por_data", bus.o_data_readed_ltchd, 32'h0);
    check("por_wen",  32'(bus.o_rf_wr_enb_ltchd), 32'h0);
    check("por_mis",  32'(bus.o_misaligned_ltchd), 32'h0);
    check("por_alu",  bus.o_alu_result_ltchd, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    op("sw10", 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 5'd0);
    op("sw20", 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h01234567, 1'b0, 5'd0);
    op("sw14", 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h14, 32'hA5A5A5A5, 1'b0, 5'd0);
    op("lw10", 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 5'd4);

    // Reset pulse in mid-cycle across an edge carrying a store that must be lost.
    @(negedge clk);
    drive(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h20, 32'hFFFFFFFF, 1'b1, 5'd6, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_data", bus.o_data_readed_ltchd, 32'h0);
    check("arst_wen",  32'(bus.o_rf_wr_enb_ltchd), 32'h0);
    check("arst_alu",  bus.o_alu_result_ltchd, 32'h0);
    check("arst_wa",   32'(bus.o_rf_wr_addr_ltchd), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);

    op("lw20_post_rst", 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h0, 1'b1, 5'd1);
    op("lb13",  1'b0, 1'b1, SIZE_BYTE, 1'b0, 32'h13, 32'h0, 1'b1, 5'd2);
    op("lbu11", 1'b0, 1'b1, SIZE_BYTE, 1'b1, 32'h11, 32'h0, 1'b1, 5'd3);
    op("lh12",  1'b0, 1'b1, SIZE_HALF, 1'b0, 32'h12, 32'h0, 1'b1, 5'd4);
    op("lhu10", 1'b0, 1'b1, SIZE_HALF, 1'b1, 32'h10, 32'h0, 1'b1, 5'd5);
    check("lhu10_const", bus.o_data_readed_ltchd, 32'h0000BEEF);

    op("sb12",  1'b1, 1'b0, SIZE_BYTE, 1'b0, 32'h12, 32'h00000055, 1'b0, 5'd0);
    op("lw10b", 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 5'd6);
    check("sb12_const", bus.o_data_readed_ltchd, 32'hDE55BEEF);

    op("rdwr20", 1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h20, 32'hCAFEF00D, 1'b1, 5'd7);
    op("lw20b",  1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h0, 1'b1, 5'd8);

    op("lw12_mis", 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h12, 32'h0, 1'b1, 5'd9);
    op("sh11_mis", 1'b1, 1'b0, SIZE_HALF, 1'b0, 32'h11, 32'h0000AAAA, 1'b0, 5'd0);
    op("lw10c",    1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 5'd10);
    op("lw_wrap",  1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h00000410, 32'h0, 1'b1, 5'd11);

    for (int t = 0; t < 4; t++) begin
      for (int z = 0; z < 2; z++) begin
        for (int f = 0; f < 2; f++) begin
          @(negedge clk);
          drive(1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, f[0]);
          bus.i_branch_type = t[1:0];
          bus.i_alu_zero    = z[0];
          bus.i_calculated_branch_addr = 32'h8000_0000 + 32'(t * 64 + z * 8 + f * 4);
          exp_pc = (f == 0) && ((t == 1 && z == 1) || (t == 2 && z == 0));
          #1;
          check($sformatf("pcsrc_t%0d_z%0d_f%0d", t, z, f), 32'(bus.o_pc_source), 32'(exp_pc));
          check($sformatf("braddr_t%0d_z%0d_f%0d", t, z, f), bus.o_branch_addr,
                32'h8000_0000 + 32'(t * 64 + z * 8 + f * 4));
        end
      end
    end

    op("lw10_pre_stall", 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 5'd3);
    @(negedge clk);
    drive(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h14, 32'h11223344, 1'b0, 5'd9, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_frozen($sformatf("stall%0d", i));
    end
    // Stall and flush together: bubble, and the pending store never commits.
    @(negedge clk);
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    check("stallflush_wen", 32'(bus.o_rf_wr_enb_ltchd), 32'h0);
    check("stallflush_mis", 32'(bus.o_misaligned_ltchd), 32'h0);
    op("lw14_unchanged", 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h14, 32'h0, 1'b1, 5'd12);

    @(negedge clk);
    drive(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h14, 32'h11223344, 1'b0, 5'd9, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    op("sw14_release", 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h14, 32'h11223344, 1'b0, 5'd9);
    op("lw14_new", 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h14, 32'h0, 1'b1, 5'd13);
    check("sw14_const", bus.o_data_readed_ltchd, 32'h11223344);
    op("lw20_final", 1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h0, 1'b1, 5'd14);

    if (sb_q.size() != 0) check("scoreboard_leftover", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
